// File: rtl/heaa_err_monitor.sv
// Error-metrics collector for a 32-bit approximate adder stream.
// Takes {a, b, approximate sum} samples, recomputes the exact sum, and accumulates
// error count, overshoot count, summed and maximum error distance over a programmed
// window of samples. The finished record is offered through a valid/ready handshake.
module heaa_err_monitor #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      win_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_a,
  input  logic [DW-1:0]         in_b,
  input  logic [DW:0]           in_sum,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      over_cnt,
  output logic [DW+CNT_W:0]     ed_sum,
  output logic [DW:0]           ed_max
);

  // Sum width and accumulated-distance width.
  localparam int unsigned SW = DW + 1;
  localparam int unsigned AW = DW + 1 + CNT_W;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  // Window bookkeeping.
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] win_q;

  // Stage 1 registers: per-sample error terms.
  logic          s1_vld_q;
  logic [SW-1:0] s1_diff_q;
  logic          s1_ne_q;
  logic          s1_gt_q;

  // Stage 2 accumulators, driven straight onto the result outputs.
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] over_cnt_q;
  logic [AW-1:0]    ed_sum_q;
  logic [SW-1:0]    ed_max_q;

  // Combinational stage-1 terms.
  logic [SW-1:0] exact;
  logic [SW-1:0] diff_d;
  logic          ne_d;
  logic          gt_d;

  logic start_ok;
  logic accept;
  logic last_acc;

  assign start_ok = (state_q == StIdle) && start;
  assign accept   = in_valid && in_ready;
  // The sample accepted now is the last one of the window.
  assign last_acc = accept && ((cnt_q + CntOne) == win_q);

  // Exact sum at full width plus the unsigned distance to the approximate sum.
  always_comb begin
    exact  = {1'b0, in_a} + {1'b0, in_b};
    ne_d   = (in_sum != exact);
    gt_d   = (in_sum > exact);
    diff_d = '0;
    if (gt_d) begin
      diff_d = in_sum - exact;
    end else begin
      diff_d = exact - in_sum;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          // An empty window has nothing to collect and reports immediately.
          state_d = (win_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_acc) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // One cycle for the last sample to leave stage 2.
        state_d = StDone;
      end
      StDone: begin
        if (res_valid && res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      StRun: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDrain: begin
        busy = 1'b1;
      end
      StDone: begin
        res_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
      end
    endcase
  end

  // Window length capture and accepted-sample counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      win_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
      win_q <= win_len;
    end else if (accept) begin
      cnt_q <= cnt_q + CntOne;
    end
  end

  // Stage 1: register the per-sample error terms at the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_diff_q <= '0;
      s1_ne_q   <= 1'b0;
      s1_gt_q   <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_diff_q <= diff_d;
        s1_ne_q   <= ne_d;
        s1_gt_q   <= gt_d;
      end
    end
  end

  // Stage 2: fold stage-1 terms into the window statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q  <= '0;
      over_cnt_q <= '0;
      ed_sum_q   <= '0;
      ed_max_q   <= '0;
    end else if (start_ok) begin
      // Statistics of the previous window stay visible until a new one is armed.
      err_cnt_q  <= '0;
      over_cnt_q <= '0;
      ed_sum_q   <= '0;
      ed_max_q   <= '0;
    end else if (s1_vld_q) begin
      err_cnt_q  <= err_cnt_q + {{(CNT_W-1){1'b0}}, s1_ne_q};
      over_cnt_q <= over_cnt_q + {{(CNT_W-1){1'b0}}, s1_gt_q};
      ed_sum_q   <= ed_sum_q + {{CNT_W{1'b0}}, s1_diff_q};
      if (s1_diff_q > ed_max_q) begin
        ed_max_q <= s1_diff_q;
      end
    end
  end

  assign err_cnt  = err_cnt_q;
  assign over_cnt = over_cnt_q;
  assign ed_sum   = ed_sum_q;
  assign ed_max   = ed_max_q;

endmodule

// File: tb/tb_heaa_err_monitor.sv
// Self-checking bench for heaa_err_monitor: directed scenarios plus randomized windows,
// compared every cycle against a window-level behavioural model.
module tb_heaa_err_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] win_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [32:0] in_sum;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] err_cnt;
  logic [15:0] over_cnt;
  logic [48:0] ed_sum;
  logic [32:0] ed_max;

  heaa_err_monitor #(
    .DW   (32),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .win_len  (win_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sum   (in_sum),
    .busy     (busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .err_cnt  (err_cnt),
    .over_cnt (over_cnt),
    .ed_sum   (ed_sum),
    .ed_max   (ed_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int PhIdle  = 0;
  localparam int PhRun   = 1;
  localparam int PhDrain = 2;
  localparam int PhDone  = 3;
  localparam longint Mask33 = 64'h1_FFFF_FFFF;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase, samples still owed, and the exact/approx sums of the current window.
  int     m_phase = PhIdle;
  int     m_left  = 0;
  bit     m_acc   = 1'b0;
  longint m_x[$];
  longint m_s[$];

  // Pending stimulus samples.
  longint qa[$];
  longint qb[$];
  longint qs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: cycle budget expired at %0t", name, $time);
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    m_acc = 1'b0;
    if (rst) begin
      m_phase = PhIdle;
      m_left  = 0;
      m_x.delete();
      m_s.delete();
    end else begin
      case (m_phase)
        PhIdle: if (start) begin
          m_x.delete();
          m_s.delete();
          m_left  = int'(win_len);
          m_phase = (win_len == 16'd0) ? PhDone : PhRun;
        end
        PhRun: if (in_valid) begin
          m_acc = 1'b1;
          m_x.push_back(longint'(in_a) + longint'(in_b));
          m_s.push_back(longint'(in_sum));
          m_left--;
          if (m_left == 0) m_phase = PhDrain;
        end
        PhDrain: m_phase = PhDone;
        default: if (res_ready) m_phase = PhIdle;
      endcase
    end
  endtask

  // Compare all DUT outputs against the model.
  task automatic compare();
    longint e_err, e_over, e_sum, e_max, d;
    chk("in_ready", longint'(in_ready), longint'(m_phase == PhRun));
    chk("busy", longint'(busy), longint'(m_phase == PhRun || m_phase == PhDrain));
    chk("res_valid", longint'(res_valid), longint'(m_phase == PhDone));
    if (m_phase == PhIdle || m_phase == PhDone) begin
      e_err = 0; e_over = 0; e_sum = 0; e_max = 0;
      foreach (m_x[i]) begin
        d = (m_x[i] > m_s[i]) ? m_x[i] - m_s[i] : m_s[i] - m_x[i];
        if (d != 0) e_err++;
        if (m_s[i] > m_x[i]) e_over++;
        e_sum += d;
        if (d > e_max) e_max = d;
      end
      chk("err_cnt", longint'(err_cnt), e_err);
      chk("over_cnt", longint'(over_cnt), e_over);
      chk("ed_sum", longint'(ed_sum), e_sum);
      chk("ed_max", longint'(ed_max), e_max);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic push(input longint a, input longint b, input longint s);
    qa.push_back(a);
    qb.push_back(b);
    qs.push_back(s);
  endtask

  task automatic gen_sample(input bit exact_only);
    longint a, b, x, s;
    a = longint'($urandom);
    b = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF - longint'($urandom_range(0, 3))
                                    : longint'($urandom);
    x = a + b;
    case (exact_only ? 0 : $urandom_range(0, 3))
      0: s = x;
      1: s = (x + longint'($urandom_range(1, 5))) & Mask33;
      2: s = (x - longint'($urandom_range(1, 5))) & Mask33;
      default: s = (longint'($urandom_range(0, 1)) << 32) | longint'($urandom);
    endcase
    push(a, b, s);
  endtask

  task automatic clear_stim();
    qa.delete();
    qb.delete();
    qs.delete();
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    win_len = 16'(len);
    tick();
    start = 1'b0;
  endtask

  // Offer samples while the window runs. mode 0: dense, 1: valid toggles, 2: random gaps.
  task automatic feed(input int mode, input int max_acc, input bit rnd_start, input bit exact);
    int acc = 0;
    for (int c = 0; c < 300 && m_phase == PhRun && acc < max_acc; c++) begin
      if (qa.size() == 0) gen_sample(exact);
      in_a     = 32'(qa[0]);
      in_b     = 32'(qb[0]);
      in_sum   = 33'(qs[0]);
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 9) > 2);
      start    = rnd_start && ($urandom_range(0, 7) == 0);
      win_len  = 16'($urandom_range(0, 9));
      tick();
      if (m_acc) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
        void'(qs.pop_front());
        acc++;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (m_phase == PhRun && acc < max_acc) bound_fail("feed_budget");
  endtask

  task automatic wait_result();
    for (int c = 0; c < 20 && m_phase != PhDone; c++) tick();
    if (m_phase != PhDone) bound_fail("wait_result");
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; win_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_sum = '0; res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_err_cnt", longint'(err_cnt), 0);

    // Basic window of three samples.
    push(1, 1, 1);
    push(3, 1, 3);
    push(5, 2, 7);
    do_start(3);
    feed(0, 100, 1'b0, 1'b0);
    chk("t1_rv_at_last_accept", longint'(res_valid), 0);
    tick();
    chk("t1_rv_one_later", longint'(res_valid), 1);
    chk("t1_err_cnt", longint'(err_cnt), 2);
    chk("t1_over_cnt", longint'(over_cnt), 0);
    chk("t1_ed_sum", longint'(ed_sum), 2);
    chk("t1_ed_max", longint'(ed_max), 1);
    handshake();

    // Carry out of bit 31 must be kept in the exact sum.
    push(64'hFFFF_FFFF, 1, 64'h0_FFFF_FFFF);
    push(0, 0, 64'h1_0000_0000);
    do_start(2);
    feed(0, 100, 1'b0, 1'b0);
    wait_result();
    chk("t2_err_cnt", longint'(err_cnt), 2);
    chk("t2_over_cnt", longint'(over_cnt), 1);
    chk("t2_ed_sum", longint'(ed_sum), 64'h1_0000_0001);
    chk("t2_ed_max", longint'(ed_max), 64'h1_0000_0000);
    handshake();

    // Gapped exact samples: exactly four counted, later offers ignored.
    clear_stim();
    do_start(4);
    feed(1, 100, 1'b0, 1'b1);
    chk("t3_in_ready_drop", longint'(in_ready), 0);
    in_valid = 1'b1;
    in_sum   = 33'h1_2345_6789;
    tick();
    in_valid = 1'b0;
    wait_result();
    chk("t3_err_cnt", longint'(err_cnt), 0);
    chk("t3_ed_sum", longint'(ed_sum), 0);
    handshake();
    clear_stim();

    // Empty window reports at once without ever going busy.
    do_start(0);
    chk("t4_res_valid", longint'(res_valid), 1);
    chk("t4_busy", longint'(busy), 0);
    chk("t4_ed_max", longint'(ed_max), 0);
    handshake();

    // Result held under back-pressure; starts in DONE are ignored.
    do_start(3);
    feed(0, 100, 1'b0, 1'b0);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      start   = 1'b1;
      win_len = 16'd7;
      tick();
    end
    res_ready = 1'b1;
    tick();
    start     = 1'b0;
    res_ready = 1'b0;
    chk("t5_idle_busy", longint'(busy), 0);
    do_start(2);
    chk("t5_restart_busy", longint'(busy), 1);
    feed(2, 100, 1'b0, 1'b0);
    wait_result();
    handshake();

    // Reset in the middle of a window discards it.
    clear_stim();
    do_start(5);
    feed(0, 2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_in_ready", longint'(in_ready), 0);
    chk("t6_busy", longint'(busy), 0);
    chk("t6_res_valid", longint'(res_valid), 0);
    chk("t6_ed_sum", longint'(ed_sum), 0);
    clear_stim();
    do_start(3);
    feed(0, 100, 1'b0, 1'b0);
    wait_result();
    handshake();

    // Randomized windows with gaps, stray starts, back-pressure and occasional resets.
    for (int it = 0; it < 40; it++) begin
      clear_stim();
      for (int c = 0; c < $urandom_range(0, 3); c++) tick();
      do_start(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0 && m_phase == PhRun) begin
        feed(2, 1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        continue;
      end
      feed(2, 100, 1'b1, 1'b0);
      in_valid = $urandom_range(0, 1) == 1;
      wait_result();
      in_valid = 1'b0;
      for (int c = 0; c < 60 && m_phase == PhDone; c++) begin
        res_ready = $urandom_range(0, 2) == 0;
        start     = $urandom_range(0, 3) == 0;
        win_len   = 16'($urandom_range(0, 5));
        tick();
      end
      res_ready = 1'b0;
      start     = 1'b0;
      if (m_phase != PhIdle) bound_fail("rand_handshake");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
